aes_128_dec_iter: RTL and testbench

AES_128_DEC_ITER -- requirements
Module: aes_128_dec_iter

---
 rtl/aes_128_dec_iter.sv | 236 +++++++++++++++++++++++
 tb/tb_aes_128_dec_iter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/aes_128_dec_iter.sv
// rtl/aes_128_dec_iter.sv - iterative AES-128 decryptor, one round per clock
// Caches the last expanded key schedule so a repeated key skips KEXP.
module aes_128_dec_iter (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] ct,
  output logic         busy,
  output logic         done,
  output logic [127:0] pt
);

  typedef enum logic [1:0] {IDLE, KEXP, DEC} state_t;

  state_t       state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         kvalid_q, kvalid_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [127:0] pt_q, pt_d;
  logic [127:0] st_q, st_d;
  logic [127:0] rk_q [0:10];

  logic         rk_we;
  logic [3:0]   rk_waddr;
  logic [127:0] rk_wdata;
  logic [3:0]   kidx;
  logic [127:0] kprev, kexp_next;
  logic [127:0] round_in, round_sr, round_sb, round_ak, round_out;
  logic         hit;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x4, x8, x16, x32, x64, x128;
    x2   = gf_mul(x, x);
    x4   = gf_mul(x2, x2);
    x8   = gf_mul(x4, x4);
    x16  = gf_mul(x8, x8);
    x32  = gf_mul(x16, x16);
    x64  = gf_mul(x32, x32);
    x128 = gf_mul(x64, x64);
    return gf_mul(gf_mul(gf_mul(x2, x4), gf_mul(x8, x16)),
                  gf_mul(gf_mul(x32, x64), x128));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] i;
    i = gf_inv(x);
    return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] y;
    y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(y);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Byte i sits at bits [127-8i -: 8]; row = i%4, column = i/4.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+4-r)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    end
    return o;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    a0 = w[31:24];
    a1 = w[23:16];
    a2 = w[15:8];
    a3 = w[7:0];
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    return {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]),
            inv_mix_col(s[63:32]), inv_mix_col(s[31:0])};
  endfunction

  // Forward key schedule: rk[rnd] derived from rk[rnd-1].
  always_comb begin
    logic [31:0] t, w0, w1, w2, w3;
    kidx      = (rnd_q == 4'd0) ? 4'd0 : rnd_q - 4'd1;
    kprev     = rk_q[kidx];
    t         = sub_word({kprev[23:0], kprev[31:24]}) ^ {rcon(rnd_q), 24'h000000};
    w0        = kprev[127:96] ^ t;
    w1        = kprev[95:64] ^ w0;
    w2        = kprev[63:32] ^ w1;
    w3        = kprev[31:0] ^ w2;
    kexp_next = {w0, w1, w2, w3};
  end

  // The initial AddRoundKey(rk10) is folded into the first DEC cycle.
  always_comb begin
    round_in  = (rnd_q == 4'd9) ? (st_q ^ rk_q[10]) : st_q;
    round_sr  = inv_shift_rows(round_in);
    round_sb  = inv_sub_bytes(round_sr);
    round_ak  = round_sb ^ rk_q[rnd_q];
    round_out = (rnd_q == 4'd0) ? round_ak : inv_mix_columns(round_ak);
  end

  assign hit = kvalid_q && (key == rk_q[0]);

  always_comb begin
    state_d  = state_q;
    rnd_d    = rnd_q;
    kvalid_d = kvalid_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    pt_d     = pt_q;
    st_d     = st_q;
    rk_we    = 1'b0;
    rk_waddr = 4'd0;
    rk_wdata = kexp_next;
    case (state_q)
      IDLE: begin
        if (start) begin
          st_d = ct;
          if (hit) begin
            state_d = DEC;
            rnd_d   = 4'd9;
          end else begin
            state_d  = KEXP;
            rnd_d    = 4'd1;
            kvalid_d = 1'b0;
            rk_we    = 1'b1;
            rk_waddr = 4'd0;
            rk_wdata = key;
          end
        end
      end
      KEXP: begin
        busy_d   = 1'b1;
        rk_we    = 1'b1;
        rk_waddr = rnd_q;
        if (rnd_q == 4'd10) begin
          state_d  = DEC;
          rnd_d    = 4'd9;
          kvalid_d = 1'b1;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      DEC: begin
        st_d = round_out;
        if (rnd_q == 4'd0) begin
          state_d = IDLE;
          pt_d    = round_out;
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;
          rnd_d  = rnd_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rnd_q    <= 4'd0;
      kvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pt_q     <= '0;
    end else begin
      state_q  <= state_d;
      rnd_q    <= rnd_d;
      kvalid_q <= kvalid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pt_q     <= pt_d;
    end
  end

  always_ff @(posedge clk) begin
    st_q <= st_d;
    if (rk_we && !rst) rk_q[rk_waddr] <= rk_wdata;
  end

  assign busy = busy_q;
  assign done = done_q;
  assign pt   = pt_q;

endmodule

// File: tb/tb_aes_128_dec_iter.sv
// tb/tb_aes_128_dec_iter.sv - directed FIPS-197 vector bench for aes_128_dec_iter
module tb_aes_128_dec_iter;

  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key;
  logic [127:0] ct;
  logic         busy;
  logic         done;
  logic [127:0] pt;

  int n_cmp = 0;
  int n_bad = 0;

  aes_128_dec_iter dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .key   (key),
    .ct    (ct),
    .busy  (busy),
    .done  (done),
    .pt    (pt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a request and returns #1 after the accept edge.
  task automatic start_block(input string tag, input logic [127:0] k, input logic [127:0] c);
    start = 1'b1;
    key   = k;
    ct    = c;
    step();
    start = 1'b0;
    chk({tag, "_done_w"}, {127'd0, done}, 128'd0);
  endtask

  // Waits for done (bounded); optional stray starts at cycles 3 and 15.
  task automatic run_vec(input string tag, input logic [127:0] k, input logic [127:0] c,
                         input logic [127:0] p, input int lat_exp, input bit inject);
    int lat;
    int bcnt;
    start_block(tag, k, c);
    lat  = 0;
    bcnt = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) bcnt++;
      if (inject && (lat == 3 || lat == 15)) begin
        start = 1'b1;
        key   = KC;
        ct    = CC;
      end else begin
        start = 1'b0;
      end
      step();
      lat++;
    end
    start = 1'b0;
    chk({tag, "_lat"}, 128'(lat), 128'(lat_exp));
    chk({tag, "_busy_n"}, 128'(bcnt), 128'(lat_exp - 1));
    chk({tag, "_pt"}, pt, p);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    key   = '0;
    ct    = '0;
    step();
    step();
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_done", {127'd0, done}, 128'd0);
    chk("rst_pt", pt, 128'd0);

    // start together with rst must not be accepted
    start = 1'b1;
    key   = KB;
    ct    = CB;
    step();
    rst   = 1'b0;
    start = 1'b0;
    step();
    chk("rst_prio_busy", {127'd0, busy}, 128'd0);
    step();

    run_vec("appb", KB, CB, PB, 20, 1'b0);
    step();
    chk("appb_done_end", {127'd0, done}, 128'd0);
    step();

    run_vec("appc", KC, CC, PC, 20, 1'b0);
    run_vec("appc_hit", KC, CC, PC, 10, 1'b0);
    step();
    chk("appc_hit_done_end", {127'd0, done}, 128'd0);
    step();

    run_vec("ignore", KB, CB, PB, 20, 1'b1);
    step();
    step();

    // reset during KEXP: cache holds KB, so KC misses
    start_block("kexp_rst", KC, CC);
    for (int i = 0; i < 6; i++) step();
    rst = 1'b1;
    step();
    chk("kexp_rst_busy", {127'd0, busy}, 128'd0);
    chk("kexp_rst_done", {127'd0, done}, 128'd0);
    chk("kexp_rst_pt", pt, 128'd0);
    rst = 1'b0;
    step();

    run_vec("rerun_b", KB, CB, PB, 20, 1'b0);
    run_vec("alt1_c", KC, CC, PC, 20, 1'b0);
    run_vec("alt2_b", KB, CB, PB, 20, 1'b0);
    run_vec("alt3_c", KC, CC, PC, 20, 1'b0);
    run_vec("alt4_b", KB, CB, PB, 20, 1'b0);
    step();
    chk("alt_done_end", {127'd0, done}, 128'd0);
    chk("alt_pt_hold", pt, PB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
